// File: rtl/tm1638_key_event.sv
// tm1638_key_event: debounces the raw TM1638 key matrix and turns accepted
// level changes into press/release events queued in a 4-entry show-ahead FIFO.
//
// Optional feature macro: TM1638_KEY_REPEAT_EN adds auto-repeat events for
// the lowest-index held key (pushed from a ninth SCAN cycle).
//
// Ports:
//   CK_i        system clock
//   XARST_i     asynchronous active-low reset
//   KEYS_i      raw key levels (1 = pressed), qualified by KEYS_VLD_i
//   KEYS_VLD_i  one-cycle strobe marking a new KEYS_i frame
//   EV_RD_i     pop request for the event FIFO
//   OVF_CLR_i   clears the sticky overflow flag
//   KEYS_STB_o  debounced key levels
//   EV_VLD_o    event FIFO non-empty
//   EV_CODE_o   head event: [4] repeat, [3] press/release, [2:0] key index
//   OVF_o       sticky flag, an event was dropped on a full FIFO
`timescale 1ns / 1ps

module tm1638_key_event #(
    parameter int unsigned C_DEB_N   = 3,
    parameter int unsigned C_REP_DLY = 125,
    parameter int unsigned C_REP_PER = 25
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic [7:0] KEYS_i,
    input  logic       KEYS_VLD_i,
    input  logic       EV_RD_i,
    input  logic       OVF_CLR_i,
    output logic [7:0] KEYS_STB_o,
    output logic       EV_VLD_o,
    output logic [4:0] EV_CODE_o,
    output logic       OVF_o
);

    if (C_DEB_N < 1 || C_DEB_N > 15 || C_REP_DLY < 1 || C_REP_PER < 1) begin : g_param_chk
        $error("tm1638_key_event: parameter out of range");
    end

    localparam logic [3:0] DebN = 4'(C_DEB_N);

`ifdef TM1638_KEY_REPEAT_EN
    localparam logic [3:0] LastIdx = 4'd8;  // slot 8 carries the repeat push
`else
    localparam logic [3:0] LastIdx = 4'd7;
`endif

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e          state_q;
    logic [3:0]      idx_q;
    logic            pend_q;
    logic [7:0]      pend_keys_q;
    logic [7:0]      stb_q;
    logic [7:0]      stb_d;
    logic [7:0]      rep_lvl_q;      // last level reported per key
    logic [7:0][3:0] deb_cnt_q;
    logic [7:0][3:0] deb_cnt_d;

    logic            frame_take;
    logic [7:0]      frame_keys;

    logic            push;
    logic [4:0]      push_code;

    logic [3:0][4:0] fifo_q;
    logic [1:0]      wr_q;
    logic [1:0]      rd_q;
    logic [2:0]      cnt_q;
    logic            ovf_q;
    logic            pop;
    logic            do_push;
    logic            ovf_set;

    // A pending frame always takes priority so frames stay in arrival order.
    always_comb begin
        frame_take = (state_q == StIdle) && (pend_q || KEYS_VLD_i);
        frame_keys = pend_q ? pend_keys_q : KEYS_i;
    end

    always_comb begin
        stb_d     = stb_q;
        deb_cnt_d = deb_cnt_q;
        if (frame_take) begin
            for (int i = 0; i < 8; i++) begin
                if (frame_keys[i] != stb_q[i]) begin
                    if (deb_cnt_q[i] + 4'd1 >= DebN) begin
                        stb_d[i]     = frame_keys[i];
                        deb_cnt_d[i] = 4'd0;
                    end else begin
                        deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
                    end
                end else begin
                    deb_cnt_d[i] = 4'd0;
                end
            end
        end
    end

`ifdef TM1638_KEY_REPEAT_EN
    localparam int unsigned RepMax = (C_REP_DLY > C_REP_PER) ? C_REP_DLY : C_REP_PER;
    localparam int unsigned RepW   = $clog2(RepMax + 1);
    localparam logic [RepW-1:0] RepDly = RepW'(C_REP_DLY);
    localparam logic [RepW-1:0] RepPer = RepW'(C_REP_PER);

    logic            rep_held_q;
    logic [2:0]      rep_key_q;
    logic [RepW-1:0] rep_cnt_q;
    logic            rep_ph_q;       // 0: waiting for first repeat, 1: periodic
    logic            rep_due_q;
    logic            held_d;
    logic [2:0]      low_d;

    always_comb begin
        held_d = |stb_d;
        low_d  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (stb_d[i]) begin
                low_d = 3'(i);
            end
        end
    end

    // Counts consumed frames since the tracked key was first seen held; the
    // count restarts after every fired repeat, switching to the period target.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            rep_held_q <= 1'b0;
            rep_key_q  <= 3'd0;
            rep_cnt_q  <= '0;
            rep_ph_q   <= 1'b0;
            rep_due_q  <= 1'b0;
        end else if (frame_take) begin
            if (!held_d) begin
                rep_held_q <= 1'b0;
                rep_cnt_q  <= '0;
                rep_ph_q   <= 1'b0;
                rep_due_q  <= 1'b0;
            end else if (!rep_held_q || (low_d != rep_key_q)) begin
                rep_held_q <= 1'b1;
                rep_key_q  <= low_d;
                rep_cnt_q  <= '0;
                rep_ph_q   <= 1'b0;
                rep_due_q  <= 1'b0;
            end else if (rep_cnt_q + RepW'(1) == (rep_ph_q ? RepPer : RepDly)) begin
                rep_cnt_q  <= '0;
                rep_ph_q   <= 1'b1;
                rep_due_q  <= 1'b1;
            end else begin
                rep_cnt_q  <= rep_cnt_q + RepW'(1);
                rep_due_q  <= 1'b0;
            end
        end else if ((state_q == StScan) && (idx_q == LastIdx)) begin
            rep_due_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        push      = 1'b0;
        push_code = 5'h00;
        if (state_q == StScan) begin
            if (!idx_q[3]) begin
                push      = stb_q[idx_q[2:0]] != rep_lvl_q[idx_q[2:0]];
                push_code = {1'b0, stb_q[idx_q[2:0]], idx_q[2:0]};
            end
`ifdef TM1638_KEY_REPEAT_EN
            else begin
                push      = rep_due_q;
                push_code = {2'b11, rep_key_q};
            end
`endif
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            pend_q      <= 1'b0;
            pend_keys_q <= 8'h00;
            stb_q       <= 8'h00;
            deb_cnt_q   <= '0;
            rep_lvl_q   <= 8'h00;
        end else begin
            stb_q     <= stb_d;
            deb_cnt_q <= deb_cnt_d;
            unique case (state_q)
                StIdle: begin
                    if (frame_take) begin
                        state_q <= StScan;
                        idx_q   <= 4'd0;
                        // A fresh strobe arriving while the slot drains refills it.
                        if (pend_q) begin
                            pend_q <= KEYS_VLD_i;
                            if (KEYS_VLD_i) begin
                                pend_keys_q <= KEYS_i;
                            end
                        end
                    end
                end
                StScan: begin
                    if (KEYS_VLD_i) begin
                        pend_q      <= 1'b1;
                        pend_keys_q <= KEYS_i;
                    end
                    // Reported level follows even if the FIFO dropped the event.
                    if (!idx_q[3]) begin
                        rep_lvl_q[idx_q[2:0]] <= stb_q[idx_q[2:0]];
                    end
                    if (idx_q == LastIdx) begin
                        state_q <= StIdle;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        pop     = EV_RD_i && (cnt_q != 3'd0);
        do_push = push && ((cnt_q != 3'd4) || pop);
        ovf_set = push && (cnt_q == 3'd4) && !pop;
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            fifo_q <= '0;
            wr_q   <= 2'd0;
            rd_q   <= 2'd0;
            cnt_q  <= 3'd0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_q[wr_q] <= push_code;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop) begin
                rd_q <= rd_q + 2'd1;
            end
            cnt_q <= cnt_q + {2'b00, do_push} - {2'b00, pop};
            // Set has priority over a simultaneous clear.
            ovf_q <= ovf_set | (ovf_q & ~OVF_CLR_i);
        end
    end

    always_comb begin
        KEYS_STB_o = stb_q;
        OVF_o      = ovf_q;
        EV_VLD_o   = (cnt_q != 3'd0);
        EV_CODE_o  = EV_VLD_o ? fifo_q[rd_q] : 5'h00;
`ifndef TM1638_KEY_REPEAT_EN
        EV_CODE_o[4] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_tm1638_key_event.sv
// Self-checking bench for tm1638_key_event: a vector table of frames,
// hand-written multi-cycle sequences, and randomized frames checked against a
// frame-level reference model.
`timescale 1ns / 1ps

module tb_tm1638_key_event;

    localparam int Deb    = 3;
    localparam int RepDly = 125;
    localparam int RepPer = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keys = 8'h00;
    logic       keys_vld = 1'b0;
    logic       ev_rd = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] keys_stb;
    logic       ev_vld;
    logic [4:0] ev_code;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];

    // Reference model state (frame granularity).
    int         m_cnt[8];
    logic [7:0] m_stb;
    logic [7:0] m_rep;
    int         m_track;
    int         m_hold;
    logic [4:0] m_ev[$];

    typedef struct {
        logic [7:0] keys;
        logic [7:0] stb;
        int         nev;
        logic [4:0] c0;
        logic [4:0] c1;
    } vec_t;

    vec_t vecs[15];

    tm1638_key_event #(
        .C_DEB_N  (Deb),
        .C_REP_DLY(RepDly),
        .C_REP_PER(RepPer)
    ) dut (
        .CK_i      (clk),
        .XARST_i   (rst_n),
        .KEYS_i    (keys),
        .KEYS_VLD_i(keys_vld),
        .EV_RD_i   (ev_rd),
        .OVF_CLR_i (ovf_clr),
        .KEYS_STB_o(keys_stb),
        .EV_VLD_o  (ev_vld),
        .EV_CODE_o (ev_code),
        .OVF_o     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        keys     = 8'h00;
        keys_vld = 1'b0;
        ev_rd    = 1'b0;
        ovf_clr  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Leaves the caller one cycle after the strobe was sampled.
    task automatic strobe(input logic [7:0] k);
        @(posedge clk);
        #1;
        keys     = k;
        keys_vld = 1'b1;
        @(posedge clk);
        #1;
        keys_vld = 1'b0;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        got_q.delete();
        while (ev_vld === 1'b1 && k < 8) begin
            got_q.push_back(ev_code);
            ev_rd = 1'b1;
            @(posedge clk);
            #1;
            ev_rd = 1'b0;
            k++;
        end
    endtask

    task automatic check_events(input string name);
        chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            chk(name, 32'(got_q[k]), 32'(exp_q[k]));
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_stb   = 8'h00;
        m_rep   = 8'h00;
        m_track = -1;
        m_hold  = 0;
        m_ev.delete();
    endfunction

    // One consumed frame: debounce, key events in index order, then repeat.
    function automatic void model_frame(input logic [7:0] f);
        int low;
        m_ev.delete();
        for (int i = 0; i < 8; i++) begin
            if (f[i] != m_stb[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == Deb) begin
                    m_stb[i] = f[i];
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (m_stb[i] != m_rep[i]) begin
                m_ev.push_back({1'b0, m_stb[i], 3'(i)});
                m_rep[i] = m_stb[i];
            end
        end
        low = -1;
        for (int i = 7; i >= 0; i--) if (m_stb[i]) low = i;
        if (low < 0) begin
            m_track = -1;
            m_hold  = 0;
        end else if (low != m_track) begin
            m_track = low;
            m_hold  = 0;
        end else begin
            m_hold++;
`ifdef TM1638_KEY_REPEAT_EN
            if (m_hold == RepDly || (m_hold > RepDly && (m_hold - RepDly) % RepPer == 0))
                m_ev.push_back({2'b11, 3'(low)});
`endif
        end
    endfunction

    initial begin
        logic [7:0] cur;
        logic [7:0] f;
        logic [7:0] one;
        int         rep_frames[$];
        int         others;

        // Frames applied from reset; expected debounced level after each.
        vecs[0]  = '{8'h04, 8'h00, 0, 5'h00, 5'h00};
        vecs[1]  = '{8'h04, 8'h00, 0, 5'h00, 5'h00};
        vecs[2]  = '{8'h04, 8'h04, 1, {2'b01, 3'd2}, 5'h00};
        vecs[3]  = '{8'h00, 8'h04, 0, 5'h00, 5'h00};
        vecs[4]  = '{8'h04, 8'h04, 0, 5'h00, 5'h00};
        vecs[5]  = '{8'h00, 8'h04, 0, 5'h00, 5'h00};
        vecs[6]  = '{8'h00, 8'h04, 0, 5'h00, 5'h00};
        vecs[7]  = '{8'h00, 8'h00, 1, {2'b00, 3'd2}, 5'h00};
        vecs[8]  = '{8'h01, 8'h00, 0, 5'h00, 5'h00};
        vecs[9]  = '{8'h00, 8'h00, 0, 5'h00, 5'h00};
        vecs[10] = '{8'h01, 8'h00, 0, 5'h00, 5'h00};
        vecs[11] = '{8'h00, 8'h00, 0, 5'h00, 5'h00};
        vecs[12] = '{8'h81, 8'h00, 0, 5'h00, 5'h00};
        vecs[13] = '{8'h81, 8'h00, 0, 5'h00, 5'h00};
        vecs[14] = '{8'h81, 8'h81, 2, 5'h08, 5'h0F};

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stb", 32'(keys_stb), 32'h00);
        chk("rst_vld", 32'(ev_vld), 32'h0);
        chk("rst_code", 32'(ev_code), 32'h00);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;

        // Pop while empty is ignored.
        ev_rd = 1'b1;
        @(posedge clk);
        #1;
        ev_rd = 1'b0;
        chk("empty_pop_vld", 32'(ev_vld), 32'h0);

        // Vector table.
        for (int v = 0; v < 15; v++) begin
            strobe(vecs[v].keys);
            chk("tbl_stb", 32'(keys_stb), 32'(vecs[v].stb));
            settle();
            exp_q.delete();
            if (vecs[v].nev > 0) exp_q.push_back(vecs[v].c0);
            if (vecs[v].nev > 1) exp_q.push_back(vecs[v].c1);
            drain();
            check_events("tbl_ev");
        end

        // Latency: third matching strobe at t.
        do_reset();
        strobe(8'h04);
        settle();
        strobe(8'h04);
        settle();
        strobe(8'h04);
        chk("lat_stb_t1", 32'(keys_stb), 32'h04);
        chk("lat_vld_t1", 32'(ev_vld), 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("lat_vld_early", 32'(ev_vld), 32'h0);
        end
        @(posedge clk);
        #1;
        chk("lat_vld_t4", 32'(ev_vld), 32'h1);
        chk("lat_code_t4", 32'(ev_code), 32'({2'b01, 3'd2}));
        settle();
        drain();
        exp_q.delete();
        exp_q.push_back({2'b01, 3'd2});
        check_events("lat_ev");

        // Pending slot: the later of two strobes during SCAN wins.
        do_reset();
        strobe(8'h01);
        strobe(8'h02);
        @(posedge clk);
        #1;
        strobe(8'h01);
        repeat (25) @(posedge clk);
        #1;
        chk("pend_stb_mid", 32'(keys_stb), 32'h00);
        strobe(8'h01);
        chk("pend_stb", 32'(keys_stb), 32'h01);
        settle();
        drain();
        exp_q.delete();
        exp_q.push_back(5'h08);
        check_events("pend_ev");

        // Overflow: all keys pressed, no reads.
        do_reset();
        strobe(8'h00);
        settle();
        repeat (3) begin
            strobe(8'hFF);
            settle();
        end
        chk("ovf_set", 32'(ovf), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_sticky", 32'(ovf), 32'h1);
        drain();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, 3'(i)});
        check_events("ovf_ev");
        chk("ovf_after_drain", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'h0);

        // Full FIFO with a pop on the same edge as a push.
        do_reset();
        strobe(8'h1F);
        settle();
        strobe(8'h1F);
        settle();
        strobe(8'h1F);
        repeat (4) @(posedge clk);
        #1;
        chk("full_head", 32'(ev_code), 32'h08);
        ev_rd = 1'b1;
        @(posedge clk);
        #1;
        ev_rd = 1'b0;
        chk("full_pp_ovf", 32'(ovf), 32'h0);
        chk("full_pp_head", 32'(ev_code), 32'h09);
        settle();
        drain();
        exp_q.delete();
        for (int i = 1; i < 5; i++) exp_q.push_back({2'b01, 3'(i)});
        check_events("full_pp_ev");
        chk("full_pp_ovf_end", 32'(ovf), 32'h0);

        // Clear held across every overflow push: set must win.
        do_reset();
        strobe(8'hFF);
        settle();
        strobe(8'hFF);
        settle();
        strobe(8'hFF);
        ovf_clr = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("clr_vs_set", 32'(ovf), 32'h1);
        settle();
        drain();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, 3'(i)});
        check_events("clr_vs_set_ev");

        // Reset during SCAN with events already queued.
        do_reset();
        strobe(8'hFF);
        settle();
        strobe(8'hFF);
        settle();
        strobe(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("rscan_pre_vld", 32'(ev_vld), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rscan_vld", 32'(ev_vld), 32'h0);
        chk("rscan_stb", 32'(keys_stb), 32'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        chk("rscan_quiet", 32'(ev_vld), 32'h0);
        strobe(8'hFF);
        settle();
        strobe(8'hFF);
        settle();
        chk("rscan_redeb_vld", 32'(ev_vld), 32'h0);
        strobe(8'hFF);
        chk("rscan_redeb_stb", 32'(keys_stb), 32'hFF);
        settle();
        drain();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, 3'(i)});
        check_events("rscan_ev");

        // Randomized frames against the reference model.
        do_reset();
        model_reset();
        cur = 8'h00;
        one = 8'h01;
        for (int fr = 0; fr < 80; fr++) begin
            if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
            f = cur;
            if ($urandom_range(0, 7) == 0) f = cur ^ (one << 3'($urandom_range(0, 7)));
            model_frame(f);
            strobe(f);
            chk("rnd_stb", 32'(keys_stb), 32'(m_stb));
            settle();
            chk("rnd_ovf", 32'(ovf), 32'(m_ev.size() > 4));
            exp_q.delete();
            for (int k = 0; k < m_ev.size() && k < 4; k++) exp_q.push_back(m_ev[k]);
            drain();
            check_events("rnd_ev");
            ovf_clr = 1'b1;
            @(posedge clk);
            #1;
            ovf_clr = 1'b0;
        end

`ifdef TM1638_KEY_REPEAT_EN
        // Auto-repeat: key 1 held for 200 frames after acceptance.
        do_reset();
        strobe(8'h02);
        settle();
        strobe(8'h02);
        settle();
        strobe(8'h02);
        settle();
        drain();
        exp_q.delete();
        exp_q.push_back(5'h09);
        check_events("rep_press");
        others = 0;
        for (int fr = 1; fr <= 200; fr++) begin
            strobe(8'h02);
            settle();
            drain();
            foreach (got_q[k]) begin
                if (got_q[k] == 5'h19) rep_frames.push_back(fr);
                else others++;
            end
        end
        chk("rep_count", 32'(rep_frames.size()), 32'd4);
        for (int k = 0; k < rep_frames.size() && k < 4; k++)
            chk("rep_frame", 32'(rep_frames[k]), 32'(RepDly + k * RepPer));
        chk("rep_others", 32'(others), 32'd0);
        exp_q.delete();
        got_q.delete();
        begin
            logic [4:0] rel_q[$];
            repeat (3) begin
                strobe(8'h00);
                settle();
                drain();
                foreach (got_q[k]) rel_q.push_back(got_q[k]);
            end
            got_q = rel_q;
        end
        exp_q.push_back(5'h01);
        check_events("rep_release");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
